fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised successor to the single-channel byte FIFO: synchronous first-word fall-through FIFO with configurable data width and depth, and configurable almost-full/almost-empty thresholds. Correctly handles simultaneous read and write, including a write into a full FIFO that is being read in the same cycle. Reports occupancy, single-cycle overflow/underflow strobes and sticky error flags. Sits between the pin-level I/O wrapper and any producer or consumer logic inside the tile.

Parameters:
WIDTH, 8, data word width in bits (>=1)
INDEX_WIDTH, 4, pointer width; DEPTH = 1<<INDEX_WIDTH entries
AF_THRESH, 12, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 4, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
ena  in  1  block enable; when low no push/pop is accepted and no error is raised
wr_en  in  1  push request
wr_data  in  WIDTH  push data
rd_en  in  1  pop request
rd_data  out  WIDTH  head entry (FWFT); 0 when empty
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_empty  out  1  count <= AE_THRESH
almost_full  out  1  count >= AF_THRESH
count  out  INDEX_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  strobe: push request rejected this cycle
underflow  out  1  strobe: pop request rejected this cycle
err_sticky  out  2  {overflow_seen, underflow_seen}
clr_err  in  1  clears err_sticky
wr_total  out  32  accepted pushes (see Optional Feature)
rd_total  out  32  accepted pops (see Optional Feature)

Behaviour:
- Single clock domain. Reset is synchronous and active-high: at a rising clk edge with reset high, head/tail pointers = 0, count = 0, err_sticky = 0, wr_total/rd_total = 0. After reset: empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0 ? 1 : 0), rd_data=0. Storage contents are not cleared. Reset takes priority over every other input in that cycle, including any in-flight push or pop.
- do_pop = ena & rd_en & ~empty.
- do_push = ena & wr_en & (~full | do_pop). A push to a full FIFO is accepted if a pop happens in the same cycle.
- A push to an empty FIFO never bypasses to the read side in the same cycle. The pushed data appears on rd_data on the cycle after the push edge (1-cycle write-to-read latency).
- On an edge with do_push: mem[head] <= wr_data, and head advances by 1 modulo DEPTH (natural wrap).
- On an edge with do_pop: tail advances by 1 modulo DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- rd_data is combinational: mem[tail] when ~empty, else all zeros. Status flags (empty, full, almost_*) are combinational decodes of the registered count.
- overflow = ena & wr_en & ~do_push; underflow = ena & rd_en & empty. Both are combinational, valid in the same cycle as the request.
- err_sticky bit is set on any cycle its strobe is high. clr_err clears both bits. If a strobe and clr_err are high in the same cycle, set wins.
- ena low: pointers, count and sticky bits hold; strobes are 0.
- Elaboration check: AE_THRESH < AF_THRESH; a violation is a fatal error.

Optional Feature:
FIFO_STATS_EN. When defined, wr_total and rd_total are 32-bit counters of accepted pushes and pops. They wrap at 2^32, reset to 0, and are not affected by clr_err. When undefined, both ports remain present but are tied to 0 and no counter flops are built.

Test Plan:
- Reset then idle, WIDTH=8, INDEX_WIDTH=4 -> empty=1, count=0, rd_data=0x00, almost_empty=1, full=0, err_sticky=0.
- Push 0x01..0x10 (16 words) -> full=1, count=16, almost_full from count 12, rd_data=0x01; a 17th push gives overflow=1 for 1 cycle and err_sticky[1]=1.
- Full FIFO, wr_en=rd_en=1 with wr_data=0xAA -> count stays 16, next rd_data=0x02, no overflow; draining all 16 returns 0x02..0x10 then 0xAA.
- Empty FIFO, rd_en=1 -> underflow=1 and err_sticky[0]=1; assert clr_err together with another underflow -> bit stays 1; clr_err alone -> 00.
- 40 push/pop pairs with pointer wrap (push 3, pop 3 repeatedly) -> data order preserved, count returns to 0; with FIFO_STATS_EN, wr_total=rd_total=120.
- Reset asserted with count=7 while wr_en=rd_en=1 -> next cycle count=0, empty=1, rd_data=0; ena=0 with wr_en=1 -> count unchanged, overflow=0.

Source files
------------

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_param
// Purpose  : Synchronous first-word fall-through FIFO with configurable width,
//            depth and almost-full/almost-empty thresholds, plus error strobes.
//            Define FIFO_STATS_EN to build the wr_total/rd_total counters.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_param #(
    parameter int WIDTH       = 8,
    parameter int INDEX_WIDTH = 4,
    parameter int AF_THRESH   = 12,
    parameter int AE_THRESH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ena,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [INDEX_WIDTH:0]   count,
    output logic                   overflow,
    output logic                   underflow,
    output logic [1:0]             err_sticky,
    input  logic                   clr_err,
    output logic [31:0]            wr_total,
    output logic [31:0]            rd_total
);

    localparam int                 DEPTH   = 1 << INDEX_WIDTH;
    localparam logic [INDEX_WIDTH:0] c_DEPTH = (INDEX_WIDTH+1)'(DEPTH);
    localparam logic [INDEX_WIDTH:0] c_AF    = (INDEX_WIDTH+1)'(AF_THRESH);
    localparam logic [INDEX_WIDTH:0] c_AE    = (INDEX_WIDTH+1)'(AE_THRESH);

    generate
        if (AE_THRESH >= AF_THRESH) begin : g_thresh_check
            $fatal(1, "fifo_sync_param: AE_THRESH must be below AF_THRESH");
        end
    endgenerate

    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [INDEX_WIDTH-1:0] r_head;
    logic [INDEX_WIDTH-1:0] r_tail;
    logic [INDEX_WIDTH:0]   r_count;
    logic [1:0]             r_err;

    logic w_do_push;
    logic w_do_pop;

    assign empty        = (r_count == '0);
    assign full         = (r_count == c_DEPTH);
    assign almost_empty = (r_count <= c_AE);
    assign almost_full  = (r_count >= c_AF);
    assign count        = r_count;
    assign err_sticky   = r_err;

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign w_do_pop  = ena & rd_en & ~empty;
    assign w_do_push = ena & wr_en & (~full | w_do_pop);

    assign overflow  = ena & wr_en & ~w_do_push;
    assign underflow = ena & rd_en & empty;

    assign rd_data   = empty ? '0 : r_mem[r_tail];

    // Storage is deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && w_do_push) begin
            r_mem[r_head] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_head <= r_head + 1'b1;
            end
            if (w_do_pop) begin
                r_tail <= r_tail + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Disabled block holds its sticky bits; a new strobe beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else if (ena) begin
            r_err <= (clr_err ? 2'b00 : r_err) | {overflow, underflow};
        end
    end

`ifdef FIFO_STATS_EN
    logic [31:0] r_wr_total;
    logic [31:0] r_rd_total;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_total <= '0;
            r_rd_total <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_total <= r_wr_total + 32'd1;
            end
            if (w_do_pop) begin
                r_rd_total <= r_rd_total + 32'd1;
            end
        end
    end

    assign wr_total = r_wr_total;
    assign rd_total = r_rd_total;
`else
    assign wr_total = '0;
    assign rd_total = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_sync_param
// Purpose  : Self-checking bench for fifo_sync_param against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_sync_param;

    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic        clk = 1'b0;
    logic        reset, ena, wr_en, rd_en, clr_err;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        empty, full, almost_empty, almost_full, overflow, underflow;
    logic [4:0]  count;
    logic [1:0]  err_sticky;
    logic [31:0] wr_total, rd_total;

    fifo_sync_param #(.WIDTH(8), .INDEX_WIDTH(4), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk(clk), .reset(reset), .ena(ena), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full), .count(count),
        .overflow(overflow), .underflow(underflow), .err_sticky(err_sticky),
        .clr_err(clr_err), .wr_total(wr_total), .rd_total(rd_total)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue contents, sticky flags and accepted-transfer totals
    logic [7:0]  q[$];
    logic [1:0]  m_err = 2'b00;
    logic [31:0] m_wr = 0, m_rd = 0;
    logic        p_push, p_pop, p_ovf, p_unf;

    function automatic logic [7:0] exp_rd();
        return (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    function automatic logic [31:0] exp_total(input logic [31:0] m);
`ifdef FIFO_STATS_EN
        return m;
`else
        return (m == 32'hFFFF_FFFF) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic drive(input logic rs, input logic e, input logic w, input logic r,
                         input logic c, input logic [7:0] d);
        reset = rs; ena = e; wr_en = w; rd_en = r; clr_err = c; wr_data = d;
        #1;
        p_pop  = e & r & (q.size() != 0);
        p_push = e & w & ((q.size() < DEPTH) | p_pop);
        p_ovf  = e & w & ~p_push;
        p_unf  = e & r & (q.size() == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_err = 2'b00; m_wr = 0; m_rd = 0;
        end else begin
            if (p_pop)  void'(q.pop_front());
            if (p_push) q.push_back(wr_data);
            if (ena) begin
                if (clr_err) m_err = 2'b00;
                m_err = m_err | {p_ovf, p_unf};
            end
            m_wr = m_wr + {31'd0, p_push};
            m_rd = m_rd + {31'd0, p_pop};
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 1, 0, 8'h55);
        tick();
        drive(0, 1, 0, 0, 0, 8'h00);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae got %b exp 1", almost_empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_af got %b exp 0", almost_full); end
        checks++; if (err_sticky !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", err_sticky); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(0, 1, 1, 0, 0, 8'(i));
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf[%0d] got %b exp 0", i, overflow); end
            tick();
            checks++; if (count !== 5'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i); end
            checks++; if (almost_full !== (i >= AF)) begin errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, (i >= AF)); end
            checks++; if (almost_empty !== (i <= AE)) begin errors++; $display("FAIL fill_ae[%0d] got %b exp %b", i, almost_empty, (i <= AE)); end
            checks++; if (rd_data !== 8'h01) begin errors++; $display("FAIL fill_head[%0d] got %h exp 01", i, rd_data); end
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
        drive(0, 1, 1, 0, 0, 8'hEE);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_strobe got %b exp 1", overflow); end
        tick();
        drive(0, 1, 0, 0, 0, 8'h00);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got %b exp 0", overflow); end
        checks++; if (err_sticky !== 2'b10) begin errors++; $display("FAIL ovf_sticky got %b exp 10", err_sticky); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d exp 16", count); end
    endtask

    task automatic test_full_rw();
        drive(0, 1, 1, 1, 0, 8'hAA);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullrw_ovf got %b exp 0", overflow); end
        tick();
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fullrw_count got %0d exp 16", count); end
        checks++; if (rd_data !== 8'h02) begin errors++; $display("FAIL fullrw_head got %h exp 02", rd_data); end
        for (int k = 0; k < DEPTH; k++) begin
            logic [7:0] want;
            want = (k < 15) ? 8'(k + 2) : 8'hAA;
            drive(0, 1, 0, 1, 0, 8'h00);
            checks++; if (rd_data !== want || want !== exp_rd()) begin errors++; $display("FAIL drain[%0d] got %h exp %h", k, rd_data, want); end
            tick();
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_underflow_clr();
        drive(0, 1, 0, 1, 0, 8'h00);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_strobe got %b exp 1", underflow); end
        tick();
        checks++; if (err_sticky !== 2'b11) begin errors++; $display("FAIL unf_sticky got %b exp 11", err_sticky); end
        drive(0, 1, 0, 1, 1, 8'h00);
        tick();
        checks++; if (err_sticky !== 2'b01) begin errors++; $display("FAIL clr_vs_unf got %b exp 01", err_sticky); end
        drive(0, 1, 0, 0, 1, 8'h00);
        tick();
        checks++; if (err_sticky !== 2'b00) begin errors++; $display("FAIL clr_alone got %b exp 00", err_sticky); end
    endtask

    task automatic test_wrap();
        drive(1, 0, 0, 0, 0, 8'h00);
        tick();
        for (int n = 0; n < 40; n++) begin
            for (int j = 0; j < 3; j++) begin
                drive(0, 1, 1, 0, 0, 8'($urandom));
                tick();
            end
            for (int j = 0; j < 3; j++) begin
                logic [7:0] want;
                want = exp_rd();
                drive(0, 1, 0, 1, 0, 8'h00);
                checks++; if (rd_data !== want) begin errors++; $display("FAIL wrap_data[%0d.%0d] got %h exp %h", n, j, rd_data, want); end
                tick();
            end
        end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", count); end
        checks++; if (wr_total !== exp_total(32'd120)) begin errors++; $display("FAIL wrap_wr_total got %0d exp %0d", wr_total, exp_total(32'd120)); end
        checks++; if (rd_total !== exp_total(32'd120)) begin errors++; $display("FAIL wrap_rd_total got %0d exp %0d", rd_total, exp_total(32'd120)); end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 7; i++) begin
            drive(0, 1, 1, 0, 0, 8'($urandom));
            tick();
        end
        checks++; if (count !== 5'd7) begin errors++; $display("FAIL mid_count got %0d exp 7", count); end
        drive(1, 1, 1, 1, 0, 8'h77);
        tick();
        drive(0, 1, 0, 0, 0, 8'h00);
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty got %b exp 1", empty); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL mid_rst_rd got %h exp 00", rd_data); end
    endtask

    task automatic test_ena_low();
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 0, 8'($urandom));
            tick();
        end
        drive(0, 0, 1, 1, 0, 8'h99);
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL ena_low_strobes got %b%b exp 00", overflow, underflow); end
        tick();
        checks++; if (count !== 5'd2) begin errors++; $display("FAIL ena_low_count got %0d exp 2", count); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(63) == 0), ($urandom_range(7) != 0), $urandom_range(1) == 1,
                  $urandom_range(1) == 1, ($urandom_range(15) == 0), 8'($urandom));
            checks++; if (overflow !== p_ovf || underflow !== p_unf) begin errors++; $display("FAIL rnd_strobes[%0d] got %b%b exp %b%b", n, overflow, underflow, p_ovf, p_unf); end
            tick();
            checks++; if (count !== 5'(q.size()) || rd_data !== exp_rd()) begin errors++; $display("FAIL rnd_state[%0d] count %0d rd %h exp count %0d rd %h", n, count, rd_data, q.size(), exp_rd()); end
            checks++; if ({empty, full, almost_empty, almost_full} !== {q.size() == 0, q.size() == DEPTH, q.size() <= AE, q.size() >= AF}) begin errors++; $display("FAIL rnd_flags[%0d] got %b%b%b%b count %0d", n, empty, full, almost_empty, almost_full, q.size()); end
            checks++; if (err_sticky !== m_err) begin errors++; $display("FAIL rnd_err[%0d] got %b exp %b", n, err_sticky, m_err); end
            checks++; if (wr_total !== exp_total(m_wr) || rd_total !== exp_total(m_rd)) begin errors++; $display("FAIL rnd_totals[%0d] got %0d/%0d exp %0d/%0d", n, wr_total, rd_total, exp_total(m_wr), exp_total(m_rd)); end
        end
    endtask

    initial begin
        reset = 1'b1; ena = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'h00;
        test_reset();
        test_fill_overflow();
        test_full_rw();
        test_underflow_clr();
        test_wrap();
        test_reset_midstream();
        test_ena_low();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
